// File: rtl/mipi_csi_pkg.sv
// Shared constants and state encoding for the CSI-2 receive packet decoder.
package mipi_csi_pkg;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_LS    = 6'h02;
    localparam logic [5:0] DT_LE    = 6'h03;
    localparam logic [5:0] DT_RAW8  = 6'h2A;
    localparam logic [5:0] DT_RAW10 = 6'h2B;
    localparam logic [5:0] DT_RAW12 = 6'h2C;

    localparam logic [7:0] SYNC_BYTE       = 8'hB8;
    localparam logic [5:0] LONG_PKT_MIN_DT = 6'h10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_WAIT_END
    } csi_state_e;

endpackage

// File: rtl/mipi_csi_ecc_calc.sv
// CSI-2 packet header ECC: six parity bits over the 24-bit {WC, DI} word.
module mipi_csi_ecc_calc (
    input  logic [23:0] data_i,
    output logic [5:0]  ecc_o
);

    // Each mask selects the data bits covered by one parity bit.
    assign ecc_o[0] = ^(data_i & 24'hF12CB7);
    assign ecc_o[1] = ^(data_i & 24'hF2555B);
    assign ecc_o[2] = ^(data_i & 24'h749A6D);
    assign ecc_o[3] = ^(data_i & 24'hB8E38E);
    assign ecc_o[4] = ^(data_i & 24'hDF03F0);
    assign ecc_o[5] = ^(data_i & 24'hEFFC00);

endmodule

// File: rtl/mipi_csi_rx_packet_decoder_nlane.sv
// N-lane CSI-2 packet decoder: sync detect, header parse, payload streaming.
// Header ECC checking is enabled by defining MIPI_CSI_RX_ECC_CHECK_EN.
module mipi_csi_rx_packet_decoder_nlane
    import mipi_csi_pkg::*;
#(
    parameter int          LANES  = 2,
    parameter logic [15:0] MAX_WC = 16'hFFFF
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 data_valid_i,
    input  logic [8*LANES-1:0]   data_i,
    output logic                 output_valid_o,
    output logic [8*LANES-1:0]   data_o,
    output logic [LANES-1:0]     keep_o,
    output logic                 last_o,
    output logic [15:0]          packet_length_o,
    output logic [5:0]           packet_type_o,
    output logic [1:0]           virtual_channel_o,
    output logic                 short_pkt_valid_o,
    output logic                 ecc_error_o
);

    localparam int          KW       = $clog2(LANES) + 1;
    localparam logic [1:0]  HDR_LAST = 2'(4 / LANES - 1);
    localparam logic [15:0] LANES_W  = 16'(LANES);
    localparam logic [LANES-1:0] ONES = {LANES{1'b1}};

    csi_state_e         state_q, state_d;
    logic [1:0]         hdr_cnt_q, hdr_cnt_d;
    logic [23:0]        hdr_buf_q, hdr_buf_d;
    logic [23:0]        hdr_now;
    logic [15:0]        remain_q, remain_d;
    logic               valid_q, valid_d;
    logic [8*LANES-1:0] data_q, data_d;
    logic [LANES-1:0]   keep_q, keep_d;
    logic [LANES-1:0]   keep_rem;
    logic               last_q, last_d;
    logic [15:0]        len_q, len_d;
    logic [5:0]         type_q, type_d;
    logic [1:0]         vc_q, vc_d;
    logic               short_q, short_d;
    logic               err_q, err_d;
    logic               ecc_bad;

    // DI and WC bytes seen so far, with the current beat's bytes merged in place.
    always_comb begin
        hdr_now = hdr_buf_q;
        for (int b = 0; b < 3; b++) begin
            if (2'(b / LANES) == hdr_cnt_q) begin
                hdr_now[8*b +: 8] = data_i[8*(b % LANES) +: 8];
            end
        end
    end

`ifdef MIPI_CSI_RX_ECC_CHECK_EN
    logic [5:0] ecc_calc;

    mipi_csi_ecc_calc u_ecc (
        .data_i (hdr_now),
        .ecc_o  (ecc_calc)
    );

    // The ECC byte is always the last header byte, so it is in the current beat.
    assign ecc_bad = (ecc_calc != data_i[8*(3 % LANES) +: 6]);
`else
    assign ecc_bad = 1'b0;
`endif

    assign keep_rem = ~(ONES << remain_q[KW-1:0]);

    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        hdr_buf_d = hdr_buf_q;
        remain_d  = remain_q;
        valid_d   = 1'b0;
        data_d    = '0;
        keep_d    = '0;
        last_d    = 1'b0;
        short_d   = 1'b0;
        err_d     = 1'b0;
        len_d     = len_q;
        type_d    = type_q;
        vc_d      = vc_q;

        case (state_q)
            ST_IDLE: begin
                if (data_valid_i && data_i == {LANES{SYNC_BYTE}}) begin
                    state_d   = ST_HEADER;
                    hdr_cnt_d = 2'd0;
                end
            end
            ST_HEADER: begin
                if (!data_valid_i) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (hdr_cnt_q != HDR_LAST) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    hdr_buf_d = hdr_now;
                end else begin
                    state_d = ST_WAIT_END;
                    // Rejected headers leave the previously latched fields untouched.
                    if (ecc_bad) begin
                        err_d = 1'b1;
                    end else if (hdr_now[5:0] < LONG_PKT_MIN_DT) begin
                        short_d = 1'b1;
                        len_d   = hdr_now[23:8];
                        type_d  = hdr_now[5:0];
                        vc_d    = hdr_now[7:6];
                    end else if (hdr_now[23:8] == 16'd0) begin
                        len_d  = hdr_now[23:8];
                        type_d = hdr_now[5:0];
                        vc_d   = hdr_now[7:6];
                    end else if (hdr_now[23:8] > MAX_WC) begin
                        err_d = 1'b1;
                    end else begin
                        len_d    = hdr_now[23:8];
                        type_d   = hdr_now[5:0];
                        vc_d     = hdr_now[7:6];
                        remain_d = hdr_now[23:8];
                        state_d  = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!data_valid_i) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    data_d  = data_i;
                    if (remain_q > LANES_W) begin
                        keep_d   = ONES;
                        remain_d = remain_q - LANES_W;
                    end else begin
                        keep_d   = keep_rem;
                        remain_d = 16'd0;
                        last_d   = 1'b1;
                        state_d  = ST_WAIT_END;
                    end
                end
            end
            ST_WAIT_END: begin
                if (!data_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            hdr_cnt_q <= 2'd0;
            hdr_buf_q <= 24'd0;
            remain_q  <= 16'd0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
            len_q     <= 16'd0;
            type_q    <= 6'd0;
            vc_q      <= 2'd0;
            short_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            hdr_buf_q <= hdr_buf_d;
            remain_q  <= remain_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            keep_q    <= keep_d;
            last_q    <= last_d;
            len_q     <= len_d;
            type_q    <= type_d;
            vc_q      <= vc_d;
            short_q   <= short_d;
            err_q     <= err_d;
        end
    end

    assign output_valid_o    = valid_q;
    assign data_o            = data_q;
    assign keep_o            = keep_q;
    assign last_o            = last_q;
    assign packet_length_o   = len_q;
    assign packet_type_o     = type_q;
    assign virtual_channel_o = vc_q;
    assign short_pkt_valid_o = short_q;
    assign ecc_error_o       = err_q;

endmodule
